cc_seq_alu: RTL and testbench
=============================

CC_SEQ_ALU -- requirements
Module: CC_SEQ_ALU

Interface
REQ-001 SHALL have parameter DATAWIDTH_BUS, default 32, operand/result width (>=4, power of two).
REQ-002 SHALL have parameter DATAWIDTH_ALU_SELECTION, default 4, opcode width.
REQ-003 SHALL have port CC_SEQ_ALU_CLOCK_50  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port CC_SEQ_ALU_RESET_InHigh  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CC_SEQ_ALU_start_In  input  1  request; accepted when busy_Out=0.
REQ-006 SHALL have port CC_SEQ_ALU_selection_InBus  input  DATAWIDTH_ALU_SELECTION  opcode.
REQ-007 SHALL have ports CC_SEQ_ALU_dataA_InBus, CC_SEQ_ALU_dataB_InBus  input  DATAWIDTH_BUS  operands.
REQ-008 SHALL have port CC_SEQ_ALU_busy_Out  output  1  high while a multi-cycle op is executing.
REQ-009 SHALL have port CC_SEQ_ALU_done_Out  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port CC_SEQ_ALU_data_OutBus  output  DATAWIDTH_BUS  registered result, held until the next completion.
REQ-011 SHALL have ports CC_SEQ_ALU_zero_OutLow, _negative_OutLow, _carry_OutLow, _overflow_OutLow  output  1 each  registered flags, active-low.
REQ-012 SHALL have port CC_SEQ_ALU_SetCode_Out  output  1  pulses with done_Out when the completed op updated the flags.

Function
REQ-013 SHALL decode opcodes: 0000 A; 0001 OR; 0010 AND; 0011 ADDCC; 0100 XOR; 0101 ANDCC; 0110 ORCC; 0111 NORCC (~(A|B)); 1000 ADD; 1001 SUB; 1010 SUBCC; 1011 A+1; 1100 SLL; 1101 SRL; 1110 SRA; 1111 MUL (low DATAWIDTH_BUS bits of unsigned product).
REQ-014 SHALL latch operands and opcode on the accepting edge; later changes on the input buses SHALL have no effect on the op in flight.
REQ-015 SHALL implement FSM states IDLE, SHIFT, MUL, DONE; busy_Out=1 only in SHIFT and MUL.
REQ-016 Single-cycle ops: IDLE/DONE + start -> DONE; done_Out high in the cycle after the accepting edge (latency 1).
REQ-017 Shift ops: shift amount = B[$clog2(DATAWIDTH_BUS)-1:0]; one bit per cycle in SHIFT; amount 0 SHALL take the single-cycle path; latency = amount+1.
REQ-018 MUL: shift-add, one multiplier bit per cycle, exactly DATAWIDTH_BUS cycles in MUL, latency DATAWIDTH_BUS+1.
REQ-019 DONE SHALL return to IDLE unless start_In=1, in which case the new request SHALL be accepted (back-to-back issue).
REQ-020 start_In while busy_Out=1 SHALL be ignored without side effects.
REQ-021 Flags SHALL update only on completion of the CC ops (0011, 0101, 0110, 0111, 1010); all other ops SHALL hold the flags.
REQ-022 Z = result==0; N = result MSB; for ADDCC C = carry-out, V = operand signs equal and result sign differs; for SUBCC C = unsigned borrow (A<B), V = operand signs differ and result sign differs from A; for logic CC ops C=V=0.
REQ-023 Each _OutLow flag SHALL equal the inverse of the corresponding flag; zero detection SHALL cover the full DATAWIDTH_BUS.
REQ-024 Arithmetic SHALL wrap modulo 2^DATAWIDTH_BUS; SRA SHALL replicate the MSB.

Reset
REQ-025 Reset asserted on a rising edge SHALL force IDLE, data_OutBus=0, busy_Out=0, done_Out=0, SetCode_Out=0, all four _OutLow flags=1, in any state including mid-SHIFT/MUL.
REQ-026 Reset SHALL dominate start_In in the same cycle; an aborted op SHALL produce no done_Out pulse.

Structure
REQ-027 Opcode constants and FSM state encodings SHALL live in shared package CC_ALU_PKG.
REQ-028 The shift-add multiplier datapath SHALL be sub-module CC_SEQ_ALU_MUL (start, operands, done, product); shifts and single-cycle ops SHALL remain in CC_SEQ_ALU.

Verification (DATAWIDTH_BUS=8)
REQ-029 ADDCC A=0x7F B=0x01 -> after 1 cycle data=0x80, overflow_OutLow=0, negative_OutLow=0, carry_OutLow=1, zero_OutLow=1, SetCode_Out=1.
REQ-030 SUBCC A=0x05 B=0x05 -> data=0x00, zero_OutLow=0, carry_OutLow=1; subsequent ADD 0x01+0x01 -> data=0x02, flags unchanged, SetCode_Out=0.
REQ-031 MUL A=0x0D B=0x0B -> busy_Out high 8 cycles, done_Out on cycle 9, data=0x8F; start_In pulsed mid-op ignored.
REQ-032 SRA A=0x90 B=0x03 -> done_Out on cycle 4, data=0xF2; SLL B=0x00 -> done_Out on cycle 1, data=A.
REQ-033 Reset asserted on cycle 4 of MUL -> next cycle IDLE, data=0x00, flags all 1, no done_Out; new ADD accepted next cycle completes normally.
REQ-034 Back-to-back: start held high across DONE with ops OR then XOR -> done_Out on two consecutive cycles with correct results.

Source files
------------

// File: rtl/cc_alu_pkg.sv
// Shared opcode constants, FSM state encoding and flag payload for the sequential ALU.
package cc_alu_pkg;

    localparam int unsigned OP_W = 4;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_A     = 4'b0000;
    localparam op_t OP_OR    = 4'b0001;
    localparam op_t OP_AND   = 4'b0010;
    localparam op_t OP_ADDCC = 4'b0011;
    localparam op_t OP_XOR   = 4'b0100;
    localparam op_t OP_ANDCC = 4'b0101;
    localparam op_t OP_ORCC  = 4'b0110;
    localparam op_t OP_NORCC = 4'b0111;
    localparam op_t OP_ADD   = 4'b1000;
    localparam op_t OP_SUB   = 4'b1001;
    localparam op_t OP_SUBCC = 4'b1010;
    localparam op_t OP_INC   = 4'b1011;
    localparam op_t OP_SLL   = 4'b1100;
    localparam op_t OP_SRL   = 4'b1101;
    localparam op_t OP_SRA   = 4'b1110;
    localparam op_t OP_MUL   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Condition flags, stored active-low so the output pins come straight off flops.
    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } flags_t;

    localparam flags_t FLAGS_RESET = 4'b1111;

    function automatic logic is_cc(input op_t op);
        return (op == OP_ADDCC) || (op == OP_ANDCC) || (op == OP_ORCC) ||
               (op == OP_NORCC) || (op == OP_SUBCC);
    endfunction

    function automatic logic is_shift(input op_t op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/cc_seq_alu_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, low W bits of the unsigned product.
module cc_seq_alu_mul
    import cc_alu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done_c,
    output logic [W-1:0] product_c
);

    localparam int unsigned CW = $clog2(W);

    logic          active_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  mcand_q;
    logic [W-1:0]  mplier_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_step;

    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    // The final step's sum is handed out combinationally so the parent can register it on the same edge.
    assign done_c    = active_q && (cnt_q == CW'(W - 1));
    assign product_c = acc_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
        end else if (active_q) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cc_seq_alu.sv
// Sequential ALU: single-cycle logic/arith, bit-serial shifts, shift-add multiply, active-low CC flags.
module cc_seq_alu
    import cc_alu_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS           = 32,
    parameter int unsigned DATAWIDTH_ALU_SELECTION = 4
) (
    input  logic                               CC_SEQ_ALU_CLOCK_50,
    input  logic                               CC_SEQ_ALU_RESET_InHigh,
    input  logic                               CC_SEQ_ALU_start_In,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_SEQ_ALU_selection_InBus,
    input  logic [DATAWIDTH_BUS-1:0]           CC_SEQ_ALU_dataA_InBus,
    input  logic [DATAWIDTH_BUS-1:0]           CC_SEQ_ALU_dataB_InBus,
    output logic                               CC_SEQ_ALU_busy_Out,
    output logic                               CC_SEQ_ALU_done_Out,
    output logic [DATAWIDTH_BUS-1:0]           CC_SEQ_ALU_data_OutBus,
    output logic                               CC_SEQ_ALU_zero_OutLow,
    output logic                               CC_SEQ_ALU_negative_OutLow,
    output logic                               CC_SEQ_ALU_carry_OutLow,
    output logic                               CC_SEQ_ALU_overflow_OutLow,
    output logic                               CC_SEQ_ALU_SetCode_Out
);

    localparam int unsigned W   = DATAWIDTH_BUS;
    localparam int unsigned SHW = $clog2(W);

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    op_t          op_in;
    logic [SHW-1:0] amt;

    assign clk   = CC_SEQ_ALU_CLOCK_50;
    assign rst   = CC_SEQ_ALU_RESET_InHigh;
    assign a     = CC_SEQ_ALU_dataA_InBus;
    assign b     = CC_SEQ_ALU_dataB_InBus;
    assign op_in = op_t'(CC_SEQ_ALU_selection_InBus);
    assign amt   = b[SHW-1:0];

    state_t         state_q, state_n;
    op_t            op_q, op_n;
    logic [W-1:0]   sh_q, sh_n;
    logic [SHW-1:0] cnt_q, cnt_n;
    logic [W-1:0]   data_q, data_n;
    flags_t         flags_q, flags_n;
    logic           done_q, done_n;
    logic           setcode_q, setcode_n;
    logic           busy_q, busy_n;

    logic           mul_start_c;
    logic           mul_done_c;
    logic [W-1:0]   mul_product_c;

    cc_seq_alu_mul #(
        .W(W)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start    (mul_start_c),
        .a        (a),
        .b        (b),
        .done_c   (mul_done_c),
        .product_c(mul_product_c)
    );

    // Single-cycle datapath on the live input buses, used only on the accepting edge.
    logic [W:0]   sum;
    logic [W-1:0] diff;
    logic [W-1:0] alu_res;
    logic         alu_c;
    logic         alu_v;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = a - b;
        alu_res = a;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_in)
            OP_A:     alu_res = a;
            OP_OR:    alu_res = a | b;
            OP_AND:   alu_res = a & b;
            OP_ADDCC: begin
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
                alu_v   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_XOR:   alu_res = a ^ b;
            OP_ANDCC: alu_res = a & b;
            OP_ORCC:  alu_res = a | b;
            OP_NORCC: alu_res = ~(a | b);
            OP_ADD:   alu_res = sum[W-1:0];
            OP_SUB:   alu_res = diff;
            OP_SUBCC: begin
                alu_res = diff;
                alu_c   = (a < b);
                alu_v   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_INC:   alu_res = a + W'(1);
            default:  alu_res = a;
        endcase
    end

    logic [W-1:0] sh_step;

    always_comb begin
        case (op_q)
            OP_SLL:  sh_step = sh_q << 1;
            OP_SRL:  sh_step = sh_q >> 1;
            default: sh_step = {sh_q[W-1], sh_q[W-1:1]};
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n     = state_q;
        op_n        = op_q;
        sh_n        = sh_q;
        cnt_n       = cnt_q;
        data_n      = data_q;
        flags_n     = flags_q;
        done_n      = 1'b0;
        setcode_n   = 1'b0;
        mul_start_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_n = ST_IDLE;
                if (CC_SEQ_ALU_start_In) begin
                    op_n = op_in;
                    if (op_in == OP_MUL) begin
                        mul_start_c = 1'b1;
                        state_n     = ST_MUL;
                    end else if (is_shift(op_in) && (amt != '0)) begin
                        sh_n    = a;
                        cnt_n   = amt;
                        state_n = ST_SHIFT;
                    end else begin
                        data_n  = alu_res;
                        done_n  = 1'b1;
                        state_n = ST_DONE;
                        if (is_cc(op_in)) begin
                            flags_n.zero     = ~(alu_res == '0);
                            flags_n.negative = ~alu_res[W-1];
                            flags_n.carry    = ~alu_c;
                            flags_n.overflow = ~alu_v;
                            setcode_n        = 1'b1;
                        end
                    end
                end
            end
            ST_SHIFT: begin
                sh_n  = sh_step;
                cnt_n = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    data_n  = sh_step;
                    done_n  = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_MUL: begin
                if (mul_done_c) begin
                    data_n  = mul_product_c;
                    done_n  = 1'b1;
                    state_n = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        busy_n = (state_n == ST_SHIFT) || (state_n == ST_MUL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_A;
            sh_q      <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            flags_q   <= FLAGS_RESET;
            done_q    <= 1'b0;
            setcode_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            op_q      <= op_n;
            sh_q      <= sh_n;
            cnt_q     <= cnt_n;
            data_q    <= data_n;
            flags_q   <= flags_n;
            done_q    <= done_n;
            setcode_q <= setcode_n;
            busy_q    <= busy_n;
        end
    end

    assign CC_SEQ_ALU_busy_Out        = busy_q;
    assign CC_SEQ_ALU_done_Out        = done_q;
    assign CC_SEQ_ALU_data_OutBus     = data_q;
    assign CC_SEQ_ALU_zero_OutLow     = flags_q.zero;
    assign CC_SEQ_ALU_negative_OutLow = flags_q.negative;
    assign CC_SEQ_ALU_carry_OutLow    = flags_q.carry;
    assign CC_SEQ_ALU_overflow_OutLow = flags_q.overflow;
    assign CC_SEQ_ALU_SetCode_Out     = setcode_q;

endmodule

// File: tb/tb_cc_seq_alu.sv
// Directed self-checking bench for cc_seq_alu at 8-bit data width.
module tb_cc_seq_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] data;
    logic       zl, nl, cl, vl;
    logic       setcode;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_fl = 4'b1111;

    always #5 clk = ~clk;

    cc_seq_alu #(
        .DATAWIDTH_BUS(8),
        .DATAWIDTH_ALU_SELECTION(4)
    ) dut (
        .CC_SEQ_ALU_CLOCK_50       (clk),
        .CC_SEQ_ALU_RESET_InHigh   (rst),
        .CC_SEQ_ALU_start_In       (start),
        .CC_SEQ_ALU_selection_InBus(sel),
        .CC_SEQ_ALU_dataA_InBus    (a),
        .CC_SEQ_ALU_dataB_InBus    (b),
        .CC_SEQ_ALU_busy_Out       (busy),
        .CC_SEQ_ALU_done_Out       (done),
        .CC_SEQ_ALU_data_OutBus    (data),
        .CC_SEQ_ALU_zero_OutLow    (zl),
        .CC_SEQ_ALU_negative_OutLow(nl),
        .CC_SEQ_ALU_carry_OutLow   (cl),
        .CC_SEQ_ALU_overflow_OutLow(vl),
        .CC_SEQ_ALU_SetCode_Out    (setcode)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic [4:0] lat;
        logic       cc;
        logic [3:0] fl;   // {z,n,c,v} active-low, used only when cc=1
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV] = '{
        '{4'h3, 8'h7F, 8'h01, 8'h80, 5'd1, 1'b1, 4'b1010},
        '{4'hA, 8'h05, 8'h05, 8'h00, 5'd1, 1'b1, 4'b0111},
        '{4'h8, 8'h01, 8'h01, 8'h02, 5'd1, 1'b0, 4'b0000},
        '{4'hF, 8'h0D, 8'h0B, 8'h8F, 5'd9, 1'b0, 4'b0000},
        '{4'hE, 8'h90, 8'h03, 8'hF2, 5'd4, 1'b0, 4'b0000},
        '{4'hC, 8'h5A, 8'h00, 8'h5A, 5'd1, 1'b0, 4'b0000},
        '{4'hD, 8'h80, 8'h07, 8'h01, 5'd8, 1'b0, 4'b0000},
        '{4'hC, 8'h81, 8'h09, 8'h02, 5'd2, 1'b0, 4'b0000},
        '{4'h9, 8'h00, 8'h01, 8'hFF, 5'd1, 1'b0, 4'b0000},
        '{4'hB, 8'hFF, 8'h00, 8'h00, 5'd1, 1'b0, 4'b0000},
        '{4'h7, 8'h0F, 8'hF0, 8'h00, 5'd1, 1'b1, 4'b0111},
        '{4'h6, 8'h80, 8'h01, 8'h81, 5'd1, 1'b1, 4'b1011},
        '{4'h5, 8'hF0, 8'h0F, 8'h00, 5'd1, 1'b1, 4'b0111},
        '{4'h3, 8'hFF, 8'h01, 8'h00, 5'd1, 1'b1, 4'b0101},
        '{4'h3, 8'h80, 8'h80, 8'h00, 5'd1, 1'b1, 4'b0100},
        '{4'hA, 8'h01, 8'h02, 8'hFF, 5'd1, 1'b1, 4'b1001},
        '{4'hA, 8'h80, 8'h01, 8'h7F, 5'd1, 1'b1, 4'b1110},
        '{4'hF, 8'hFF, 8'hFF, 8'h01, 5'd9, 1'b0, 4'b0000},
        '{4'h0, 8'h3C, 8'h99, 8'h3C, 5'd1, 1'b0, 4'b0000},
        '{4'h1, 8'h0C, 8'h30, 8'h3C, 5'd1, 1'b0, 4'b0000},
        '{4'h2, 8'hF0, 8'h3C, 8'h30, 5'd1, 1'b0, 4'b0000},
        '{4'h4, 8'hFF, 8'h0F, 8'hF0, 5'd1, 1'b0, 4'b0000}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, disturb buses and start while busy, then check latency, result and flags.
    task automatic run_op(input string tag, input vec_t v);
        int lat;
        int busy_cnt;
        start = 1'b1; sel = v.sel; a = v.a; b = v.b;
        tick();
        start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (busy && lat == 1) begin a = ~v.a; b = v.b ^ 8'h05; end
            if (busy && lat == 2) begin start = 1'b1; sel = 4'h8; end
            tick();
            start = 1'b0;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(v.lat));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(v.lat) - 32'd1);
        check({tag, " data"}, 32'(data), 32'(v.d));
        check({tag, " setcode"}, 32'(setcode), 32'(v.cc));
        if (v.cc) exp_fl = v.fl;
        check({tag, " flags"}, 32'({zl, nl, cl, vl}), 32'(exp_fl));
        tick();
        check({tag, " done_drop"}, 32'(done), 32'd0);
        check({tag, " data_hold"}, 32'(data), 32'(v.d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; sel = 4'h0; a = 8'h00; b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset data", 32'(data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset setcode", 32'(setcode), 32'd0);
        check("reset flags", 32'({zl, nl, cl, vl}), 32'hF);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in cycle 4 of a multiply, with start also high.
        start = 1'b1; sel = 4'hF; a = 8'h0D; b = 8'h0B;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("mul_mid busy", 32'(busy), 32'd1);
        rst = 1'b1; start = 1'b1; sel = 4'h8;
        tick();
        rst = 1'b0; start = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort data", 32'(data), 32'd0);
        check("abort setcode", 32'(setcode), 32'd0);
        check("abort flags", 32'({zl, nl, cl, vl}), 32'hF);
        exp_fl = 4'b1111;
        run_op("post_abort_add", '{4'h8, 8'h10, 8'h20, 8'h30, 5'd1, 1'b0, 4'b0000});
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            tick();
        end
        check("abort no_done", 32'(ndone), 32'd0);

        // Back-to-back: start held through the DONE cycle.
        start = 1'b1; sel = 4'h1; a = 8'h0C; b = 8'h30;
        tick();
        check("b2b or done", 32'(done), 32'd1);
        check("b2b or data", 32'(data), 32'h3C);
        sel = 4'h4; a = 8'h0F; b = 8'hFF;
        tick();
        start = 1'b0;
        check("b2b xor done", 32'(done), 32'd1);
        check("b2b xor data", 32'(data), 32'hF0);
        tick();
        check("b2b idle done", 32'(done), 32'd0);
        check("b2b flags", 32'({zl, nl, cl, vl}), 32'(exp_fl));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
